emu_run_ctrl: RTL and testbench

- Host-facing run/checkpoint sequencer for the emulated DUT. Replaces ad-hoc pause/step/count glue.
- Gates target execution: free run, exact N-cycle step, pause on trigger.
- Maintains the target cycle counter.
- Sequences FF and RAM scan chains for checkpoint save/load over 64-bit valid/ready streams. The scan clock advances only on stream handshakes.

---
 rtl/emu_run_ctrl_pkg.sv | 34 +++
 rtl/emu_run_ctrl_if.sv | 25 ++
 rtl/emu_scan_seq.sv | 41 ++++
 rtl/emu_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_emu_run_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/emu_run_ctrl_pkg.sv
// Shared types for the emulator run/checkpoint sequencer: op codes, FSM states,
// pause causes.
package emu_run_ctrl_pkg;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    OP_RUN       = 3'd0,
    OP_STEP      = 3'd1,
    OP_PAUSE     = 3'd2,
    OP_SAVE      = 3'd3,
    OP_LOAD      = 3'd4,
    OP_SET_COUNT = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_PAUSED,
    ST_RUN,
    ST_SAVE_FF,
    ST_SAVE_RAM,
    ST_LOAD_FF,
    ST_LOAD_RAM
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_CMD  = 2'd0,
    CAUSE_STEP = 2'd1,
    CAUSE_TRIG = 2'd2
  } cause_e;

  function automatic logic is_scan(state_e s);
    return (s == ST_SAVE_FF) || (s == ST_SAVE_RAM) ||
           (s == ST_LOAD_FF) || (s == ST_LOAD_RAM);
  endfunction
endpackage

// File: rtl/emu_run_ctrl_if.sv
// Host-side bus: command channel plus checkpoint save/load streams.
interface emu_run_ctrl_if;
  import emu_run_ctrl_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_arg;
  logic              sout_valid;
  logic              sout_ready;
  logic [DATA_W-1:0] sout_data;
  logic              sin_valid;
  logic              sin_ready;
  logic [DATA_W-1:0] sin_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, sout_ready, sin_valid, sin_data,
    output cmd_ready, sout_valid, sout_data, sin_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_arg, sout_ready, sin_valid, sin_data,
    input  cmd_ready, sout_valid, sout_data, sin_ready
  );
endinterface

// File: rtl/emu_scan_seq.sv
// One scan-chain walk: handshake-gated shift enable and a word counter that
// flags the final word. Shared between the FF and RAM chains by the top.
module emu_scan_seq
  import emu_run_ctrl_pkg::*;
#(
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              active,
  input  logic              load,
  input  logic [WCNT_W-1:0] n_words,
  input  logic              sout_ready,
  input  logic              sin_valid,
  input  logic [DATA_W-1:0] sin_data,
  input  logic [DATA_W-1:0] sdo,
  output logic              shift,
  output logic              sout_valid,
  output logic [DATA_W-1:0] sout_data,
  output logic              sin_ready,
  output logic [DATA_W-1:0] sdi,
  output logic              last
);
  logic [WCNT_W-1:0] wcnt;

  assign sout_valid = active & ~load;
  assign sin_ready  = active & load;
  assign sout_data  = sdo;
  assign sdi        = sin_data;
  // the scan clock only advances on a stream handshake
  assign shift      = (sout_valid & sout_ready) | (sin_ready & sin_valid);
  assign last       = shift && (wcnt == n_words - 1'b1);

  always_ff @(posedge clk) begin
    if (!resetn || clr)
      wcnt <= '0;
    else if (shift)
      wcnt <= last ? '0 : wcnt + 1'b1;
  end
endmodule

// File: rtl/emu_run_ctrl.sv
// Run/step/pause gating of the emulated target, its cycle counter, and
// checkpoint save/load sequencing over the FF then RAM scan chains.
module emu_run_ctrl
  import emu_run_ctrl_pkg::*;
#(
  parameter int FF_WORDS  = 16,
  parameter int RAM_WORDS = 64,
  parameter int WCNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  emu_run_ctrl_if.slave     bus,
  output logic              done,
  output logic              err,
  output logic              paused,
  output logic [1:0]        pause_cause,
  input  logic              trig,
  input  logic              dut_stall,
  output logic              dut_clk_en,
  output logic [DATA_W-1:0] count,
  output logic              ff_scan,
  output logic              ff_dir,
  output logic              ram_scan,
  output logic              ram_dir,
  output logic [DATA_W-1:0] ff_sdi,
  output logic [DATA_W-1:0] ram_sdi,
  input  logic [DATA_W-1:0] ff_sdo,
  input  logic [DATA_W-1:0] ram_sdo
);
  localparam logic [WCNT_W-1:0] FF_N  = WCNT_W'(FF_WORDS);
  localparam logic [WCNT_W-1:0] RAM_N = WCNT_W'(RAM_WORDS);

  state_e            state, state_n;
  cause_e            cause, cause_n;
  logic [DATA_W-1:0] rem, rem_n, count_n;
  logic              done_n, err_n, clk_en;
  logic              cmd_fire, ff_phase, seq_load, seq_clr;
  logic              shift, last;
  logic [DATA_W-1:0] sdi;

  assign bus.cmd_ready = (state == ST_PAUSED) || (state == ST_RUN);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign paused        = (state == ST_PAUSED);
  assign pause_cause   = cause;
  assign dut_clk_en    = clk_en;

  assign ff_phase = (state == ST_SAVE_FF) || (state == ST_LOAD_FF);
  assign seq_load = (state == ST_LOAD_FF) || (state == ST_LOAD_RAM);
  assign seq_clr  = (state_n != state) && is_scan(state_n);

  emu_scan_seq #(.WCNT_W(WCNT_W)) u_seq (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (seq_clr),
    .active     (is_scan(state)),
    .load       (seq_load),
    .n_words    (ff_phase ? FF_N : RAM_N),
    .sout_ready (bus.sout_ready),
    .sin_valid  (bus.sin_valid),
    .sin_data   (bus.sin_data),
    .sdo        (ff_phase ? ff_sdo : ram_sdo),
    .shift      (shift),
    .sout_valid (bus.sout_valid),
    .sout_data  (bus.sout_data),
    .sin_ready  (bus.sin_ready),
    .sdi        (sdi),
    .last       (last)
  );

  assign ff_scan  = ff_phase & shift;
  assign ram_scan = is_scan(state) & ~ff_phase & shift;
  assign ff_dir   = (state == ST_LOAD_FF);
  assign ram_dir  = (state == ST_LOAD_RAM);
  assign ff_sdi   = sdi;
  assign ram_sdi  = sdi;

  always_comb begin
    state_n = state;
    cause_n = cause;
    rem_n   = rem;
    count_n = count;
    done_n  = 1'b0;
    err_n   = 1'b0;
    clk_en  = 1'b0;
    case (state)
      ST_PAUSED: if (cmd_fire) begin
        case (bus.cmd_op)
          OP_RUN:  state_n = ST_RUN;
          OP_STEP: if (bus.cmd_arg != '0) begin
            rem_n   = bus.cmd_arg;
            state_n = ST_RUN;
          end else
            done_n = 1'b1;
          OP_PAUSE: done_n  = 1'b1;
          OP_SAVE:  state_n = ST_SAVE_FF;
          OP_LOAD:  state_n = ST_LOAD_FF;
          OP_SET_COUNT: begin
            count_n = bus.cmd_arg;
            done_n  = 1'b1;
          end
          default: err_n = 1'b1;
        endcase
      end
      ST_RUN: begin
        clk_en = !dut_stall;
        if (clk_en) begin
          count_n = count + 1'b1;
          if (rem != '0) rem_n = rem - 1'b1;
        end
        if (cmd_fire && bus.cmd_op != OP_PAUSE) err_n = 1'b1;
        // rem==0 means unbounded, so only a bounded run can hit rem==1
        if (trig || (clk_en && rem == 64'd1) || (cmd_fire && bus.cmd_op == OP_PAUSE)) begin
          state_n = ST_PAUSED;
          rem_n   = '0;
          done_n  = 1'b1;
          if (trig)                           cause_n = CAUSE_TRIG;
          else if (clk_en && rem == 64'd1)    cause_n = CAUSE_STEP;
          else                                cause_n = CAUSE_CMD;
        end
      end
      ST_SAVE_FF:  if (last) state_n = ST_SAVE_RAM;
      ST_LOAD_FF:  if (last) state_n = ST_LOAD_RAM;
      ST_SAVE_RAM, ST_LOAD_RAM: if (last) begin
        state_n = ST_PAUSED;
        done_n  = 1'b1;
      end
      default: state_n = ST_PAUSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_PAUSED;
      cause <= CAUSE_CMD;
      rem   <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      rem   <= rem_n;
      count <= count_n;
      done  <= done_n;
      err   <= err_n;
    end
  end
endmodule

// File: tb/tb_emu_run_ctrl.sv
// Randomized bench for emu_run_ctrl with a small FF/RAM chain model.
module tb_emu_run_ctrl;
  import emu_run_ctrl_pkg::*;

  localparam int FFW  = 2;
  localparam int RAMW = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        trig = 1'b0, dut_stall = 1'b0;
  logic        done, err, paused, dut_clk_en;
  logic [1:0]  pause_cause;
  logic [63:0] count, ff_sdi, ram_sdi, ff_sdo, ram_sdo;
  logic        ff_scan, ff_dir, ram_scan, ram_dir;

  int vecs = 0;
  int errs = 0;
  logic [63:0] m_count = '0;
  logic [1:0]  m_cause = 2'd0;

  logic [63:0] ff_ch[FFW], ram_ch[RAMW];
  logic [63:0] ff_seed[FFW], ram_seed[RAMW];

  always #5 clk = ~clk;

  emu_run_ctrl_if bus();

  emu_run_ctrl #(.FF_WORDS(FFW), .RAM_WORDS(RAMW), .WCNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .done(done), .err(err), .paused(paused), .pause_cause(pause_cause),
    .trig(trig), .dut_stall(dut_stall), .dut_clk_en(dut_clk_en), .count(count),
    .ff_scan(ff_scan), .ff_dir(ff_dir), .ram_scan(ram_scan), .ram_dir(ram_dir),
    .ff_sdi(ff_sdi), .ram_sdi(ram_sdi), .ff_sdo(ff_sdo), .ram_sdo(ram_sdo)
  );

  // recirculating chains: head word is visible, shift moves toward the head
  assign ff_sdo  = ff_ch[0];
  assign ram_sdo = ram_ch[0];
  always @(posedge clk) begin
    if (!resetn) begin
      ff_ch  <= ff_seed;
      ram_ch <= ram_seed;
    end else begin
      if (ff_scan) begin
        for (int i = 0; i < FFW-1; i++) ff_ch[i] <= ff_ch[i+1];
        ff_ch[FFW-1] <= ff_dir ? ff_sdi : ff_ch[0];
      end
      if (ram_scan) begin
        for (int i = 0; i < RAMW-1; i++) ram_ch[i] <= ram_ch[i+1];
        ram_ch[RAMW-1] <= ram_dir ? ram_sdi : ram_ch[0];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] arg);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick(); tick();
    vecs++; if (paused !== 1'b1) begin errs++; $display("FAIL reset_paused: got %b want 1", paused); end
    vecs++; if (count !== 64'd0) begin errs++; $display("FAIL reset_count: got %h want 0", count); end
    vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    vecs++; if ({done, err, dut_clk_en, bus.sout_valid, bus.sin_ready, ff_scan, ff_dir, ram_scan, ram_dir, pause_cause} !== 11'd0) begin
      errs++; $display("FAIL reset_outs: got %b want 0", {done, err, dut_clk_en, bus.sout_valid, bus.sin_ready, ff_scan, ff_dir, ram_scan, ram_dir, pause_cause});
    end
    resetn = 1'b1;
    m_count = '0; m_cause = 2'd0;
  endtask

  // mask bit i stalls the i-th RUN cycle; the run ends on the n-th unstalled cycle
  task automatic test_step(input string nm, input int n, input logic [63:0] mask);
    int en, cyc, exp_cyc, z;
    z = 0; exp_cyc = 0;
    for (int i = 0; i < 200; i++)
      if (z < n) begin exp_cyc++; if (i >= 64 || !mask[i]) z++; end
    send(OP_STEP, 64'(n));
    en = 0; cyc = 0;
    while (!paused && cyc < 200) begin
      dut_stall = (cyc < 64) ? mask[cyc] : 1'b0;
      #1;
      if (dut_clk_en) en++;
      cyc++;
      @(posedge clk); #1;
    end
    dut_stall = 1'b0;
    m_count = m_count + 64'(n); m_cause = 2'd1;
    vecs++; if (en !== n) begin errs++; $display("FAIL %s_en: got %0d want %0d", nm, en, n); end
    vecs++; if (cyc !== exp_cyc) begin errs++; $display("FAIL %s_cycles: got %0d want %0d", nm, cyc, exp_cyc); end
    vecs++; if (count !== m_count) begin errs++; $display("FAIL %s_count: got %h want %h", nm, count, m_count); end
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL %s_done: got %b want 1", nm, done); end
    vecs++; if (pause_cause !== m_cause) begin errs++; $display("FAIL %s_cause: got %0d want %0d", nm, pause_cause, m_cause); end
  endtask

  task automatic test_trig(input string nm, input int k, input bit with_pause, input logic [63:0] mask);
    int en, cyc;
    send(OP_RUN, '0);
    en = 0; cyc = 0;
    while (!paused && cyc < 300) begin
      dut_stall = (cyc < 64) ? mask[cyc] : 1'b0;
      #1;
      if (dut_clk_en) begin
        en++;
        if (en == k) begin
          trig = 1'b1;
          if (with_pause) begin bus.cmd_valid = 1'b1; bus.cmd_op = OP_PAUSE; end
        end
      end
      cyc++;
      @(posedge clk); #1;
      trig = 1'b0; bus.cmd_valid = 1'b0;
    end
    dut_stall = 1'b0;
    m_count = m_count + 64'(k); m_cause = 2'd2;
    vecs++; if (count !== m_count) begin errs++; $display("FAIL %s_count: got %h want %h", nm, count, m_count); end
    vecs++; if (pause_cause !== m_cause) begin errs++; $display("FAIL %s_cause: got %0d want %0d", nm, pause_cause, m_cause); end
    vecs++; if ({paused, done, err} !== 3'b110) begin errs++; $display("FAIL %s_flags: got %b want 110", nm, {paused, done, err}); end
  endtask

  task automatic test_pause_cmd();
    int r;
    r = $urandom_range(3, 8);
    send(OP_RUN, '0);
    repeat (r) tick();
    send(OP_SAVE, '0);
    vecs++; if ({err, paused} !== 2'b10) begin errs++; $display("FAIL run_err: got %b want 10", {err, paused}); end
    send(OP_PAUSE, '0);
    m_count = m_count + 64'(r + 2); m_cause = 2'd0;
    vecs++; if (count !== m_count) begin errs++; $display("FAIL pause_count: got %h want %h", count, m_count); end
    vecs++; if ({paused, done, err, pause_cause} !== {3'b110, m_cause}) begin
      errs++; $display("FAIL pause_flags: got %b want %b", {paused, done, err, pause_cause}, {3'b110, m_cause});
    end
  endtask

  task automatic test_set_count_wrap();
    send(OP_SET_COUNT, 64'hFFFF_FFFF_FFFF_FFFF);
    m_count = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs++; if ({done, count} !== {1'b1, m_count}) begin errs++; $display("FAIL set_count: got %b/%h want 1/%h", done, count, m_count); end
    test_step("wrap", 2, 64'd0);
    vecs++; if (count !== 64'd1) begin errs++; $display("FAIL wrap_value: got %h want 1", count); end
  endtask

  task automatic test_zero_and_illegal();
    send(OP_STEP, '0);
    vecs++; if ({done, paused, dut_clk_en, err} !== 4'b1100) begin errs++; $display("FAIL step0_flags: got %b want 1100", {done, paused, dut_clk_en, err}); end
    vecs++; if (count !== m_count) begin errs++; $display("FAIL step0_count: got %h want %h", count, m_count); end
    send(3'd7, 64'd3);
    vecs++; if ({err, done} !== 2'b10) begin errs++; $display("FAIL op7_err: got %b want 10", {err, done}); end
    send(3'd6, 64'd0);
    vecs++; if ({err, done} !== 2'b10) begin errs++; $display("FAIL op6_err: got %b want 10", {err, done}); end
  endtask

  task automatic test_save(input string nm, input logic [63:0] expw[FFW+RAMW]);
    logic [63:0] got[$];
    int ffc, ramc, dn, cyc, rdy;
    send(OP_SAVE, '0);
    ffc = 0; ramc = 0; dn = 0; cyc = 0; rdy = 0;
    while (!paused && cyc < 200) begin
      bus.sout_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.sout_valid && bus.sout_ready) got.push_back(bus.sout_data);
      if (ff_scan) ffc++;
      if (ram_scan) ramc++;
      if (bus.cmd_ready) rdy++;
      cyc++;
      @(posedge clk); #1;
      if (done) dn++;
    end
    bus.sout_ready = 1'b0;
    vecs++; if (got.size() !== FFW+RAMW) begin errs++; $display("FAIL %s_words: got %0d want %0d", nm, got.size(), FFW+RAMW); end
    for (int i = 0; i < FFW+RAMW && i < got.size(); i++) begin
      vecs++; if (got[i] !== expw[i]) begin errs++; $display("FAIL %s_word%0d: got %h want %h", nm, i, got[i], expw[i]); end
    end
    vecs++; if ({ffc, ramc} !== {FFW, RAMW}) begin errs++; $display("FAIL %s_scans: got ff=%0d ram=%0d want %0d/%0d", nm, ffc, ramc, FFW, RAMW); end
    vecs++; if ({dn, rdy} !== {32'd1, 32'd0}) begin errs++; $display("FAIL %s_done: got done=%0d ready=%0d want 1/0", nm, dn, rdy); end
    vecs++; if (pause_cause !== m_cause) begin errs++; $display("FAIL %s_cause: got %0d want %0d", nm, pause_cause, m_cause); end
    for (int i = 0; i < FFW; i++) begin
      vecs++; if (ff_ch[i] !== expw[i]) begin errs++; $display("FAIL %s_ff_kept%0d: got %h want %h", nm, i, ff_ch[i], expw[i]); end
    end
  endtask

  task automatic test_load(input logic [63:0] w[FFW+RAMW]);
    int idx, dn, cyc;
    send(OP_LOAD, '0);
    idx = 0; dn = 0; cyc = 0;
    while (!paused && cyc < 200) begin
      bus.sin_valid = 1'($urandom_range(0, 1));
      bus.sin_data  = (idx < FFW+RAMW) ? w[idx] : 64'd0;
      #1;
      if (bus.sin_valid && bus.sin_ready) idx++;
      cyc++;
      @(posedge clk); #1;
      if (done) dn++;
    end
    bus.sin_valid = 1'b0;
    vecs++; if ({idx, dn} !== {FFW+RAMW, 32'd1}) begin errs++; $display("FAIL load_words: got %0d/%0d want %0d/1", idx, dn, FFW+RAMW); end
    for (int i = 0; i < RAMW; i++) begin
      vecs++; if (ram_ch[i] !== w[FFW+i]) begin errs++; $display("FAIL load_ram%0d: got %h want %h", i, ram_ch[i], w[FFW+i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    send(OP_RUN, '0);
    repeat (4) tick();
    resetn = 1'b0; tick(); resetn = 1'b1;
    m_count = '0; m_cause = 2'd0;
    vecs++; if ({paused, dut_clk_en, pause_cause} !== 4'b1000) begin errs++; $display("FAIL midreset_flags: got %b want 1000", {paused, dut_clk_en, pause_cause}); end
    vecs++; if (count !== m_count) begin errs++; $display("FAIL midreset_count: got %h want 0", count); end
  endtask

  initial begin
    logic [63:0] seedw[FFW+RAMW], loadw[FFW+RAMW];
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_arg = '0;
    bus.sout_ready = 1'b0; bus.sin_valid = 1'b0; bus.sin_data = '0;
    for (int i = 0; i < FFW+RAMW; i++) begin
      seedw[i] = {$urandom, $urandom};
      loadw[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < FFW; i++)  ff_seed[i]  = seedw[i];
    for (int i = 0; i < RAMW; i++) ram_seed[i] = seedw[FFW+i];

    test_reset();
    test_step("step5", 5, 64'd0);
    test_step("step4_stall", 4, 64'h2A);
    for (int i = 0; i < 3; i++)
      test_step("step_rand", $urandom_range(1, 12), {$urandom, $urandom} & {$urandom, $urandom});
    test_trig("trig10", 10, 1'b0, {$urandom, $urandom} & {$urandom, $urandom});
    test_trig("trig_pause", 10, 1'b1, 64'd0);
    test_pause_cmd();
    test_set_count_wrap();
    test_zero_and_illegal();
    test_save("save_seed", seedw);
    test_load(loadw);
    test_save("save_loaded", loadw);
    test_reset_mid_run();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
